count_sequence_checker: RTL and testbench



---
 rtl/count_chk_pkg.sv | 21 ++
 rtl/count_chk_next.sv | 32 +++
 rtl/count_sequence_checker.sv | 169 ++++++++++++++++
 tb/tb_count_sequence_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_chk_pkg.sv
// ============================================================================
// Module  : count_chk_pkg
// Brief   : Shared types and constants for the count sequence checker.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package count_chk_pkg;

  localparam int DATA_W            = 4;
  localparam int DEFAULT_MAX_COUNT = 7;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

endpackage

`default_nettype wire

// File: rtl/count_chk_next.sv
// ============================================================================
// Module  : count_chk_next
// Brief   : Combinational next-value generator for the wrapping count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module count_chk_next
  import count_chk_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic [DATA_W-1:0] x,
  input  logic              dir,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] c_max = DATA_W'(MAX_COUNT);
  localparam logic [DATA_W-1:0] c_one = DATA_W'(1);

  always_comb begin
    y = '0;
    if (dir) begin
      y = (x == '0) ? c_max : x - c_one;
    end else begin
      y = (x == c_max) ? '0 : x + c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/count_sequence_checker.sv
// ============================================================================
// Module  : count_sequence_checker
// Brief   : Locks to a wrapping count stream, flags and counts misses.
//           Define COUNT_CHK_DOWN_EN to add the dir input (down-count mode).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module count_sequence_checker
  import count_chk_pkg::*;
#(
  parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter int LOCK_COUNT  = 3,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 re_n,
  input  logic                 din_valid,
  input  logic [DATA_W-1:0]    din,
`ifdef COUNT_CHK_DOWN_EN
  input  logic                 dir,
`endif
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [DATA_W-1:0]    expected,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [DATA_W-1:0]    c_max           = DATA_W'(MAX_COUNT);
  localparam logic [GOOD_W-1:0]    c_good_one      = GOOD_W'(1);
  localparam logic [GOOD_W-1:0]    c_lock_target   = GOOD_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0]     c_bad_one       = BAD_W'(1);
  localparam logic [BAD_W-1:0]     c_unlock_target = BAD_W'(UNLOCK_ERRS);
  localparam logic [ERR_CNT_W-1:0] c_err_one       = ERR_CNT_W'(1);

  chk_state_t           r_state;
  logic                 r_locked;
  logic                 r_err_pulse;
  logic                 r_wrap_pulse;
  logic [DATA_W-1:0]    r_expected;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [GOOD_W-1:0]    r_good;
  logic [BAD_W-1:0]     r_bad;

  logic                 w_dir;
  logic [DATA_W-1:0]    w_seed;
  logic [DATA_W-1:0]    w_fly;
  logic [DATA_W-1:0]    w_wrap_val;
  logic                 w_legal;
  logic                 w_match;
  logic                 w_err_inc;

`ifdef COUNT_CHK_DOWN_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  // Seed path re-acquires from din; flywheel path advances the current guess.
  count_chk_next #(.MAX_COUNT(MAX_COUNT)) u_next_seed (
    .x   (din),
    .dir (w_dir),
    .y   (w_seed)
  );

  count_chk_next #(.MAX_COUNT(MAX_COUNT)) u_next_fly (
    .x   (r_expected),
    .dir (w_dir),
    .y   (w_fly)
  );

  assign w_wrap_val = w_dir ? '0 : c_max;
  assign w_legal    = (din <= c_max);
  assign w_match    = (din == r_expected);
  assign w_err_inc  = din_valid && (r_state == LOCKED) && !w_match;

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      r_state      <= HUNT;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_expected   <= '0;
      r_err_count  <= '0;
      r_good       <= '0;
      r_bad        <= '0;
    end else begin
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;

      if (err_clr) begin
        r_err_count <= '0;
      end else if (w_err_inc && (r_err_count != '1)) begin
        r_err_count <= r_err_count + c_err_one;
      end

      if (din_valid) begin
        case (r_state)
          HUNT: begin
            if (w_legal) begin
              r_expected <= w_seed;
              r_good     <= c_good_one;
              if (LOCK_COUNT == 1) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_bad    <= '0;
              end else begin
                r_state  <= SYNC;
              end
            end
          end
          SYNC: begin
            if (w_match) begin
              r_expected <= w_fly;
              r_good     <= r_good + c_good_one;
              if ((r_good + c_good_one) == c_lock_target) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_bad    <= '0;
              end
            end else if (w_legal) begin
              r_expected <= w_seed;
              r_good     <= c_good_one;
            end else begin
              r_state    <= HUNT;
              r_good     <= '0;
            end
          end
          LOCKED: begin
            r_expected <= w_fly;
            if (w_match) begin
              r_bad        <= '0;
              r_wrap_pulse <= (din == w_wrap_val);
            end else begin
              r_err_pulse <= 1'b1;
              if ((r_bad + c_bad_one) == c_unlock_target) begin
                r_state  <= HUNT;
                r_locked <= 1'b0;
                r_bad    <= '0;
                r_good   <= '0;
              end else begin
                r_bad    <= r_bad + c_bad_one;
              end
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign expected   = r_expected;
  assign err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_count_sequence_checker.sv
// ============================================================================
// Module  : tb_count_sequence_checker
// Brief   : Directed self-checking bench for count_sequence_checker.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_count_sequence_checker;

  logic       clk = 1'b0;
  logic       re_n = 1'b0;
  logic       din_valid = 1'b0;
  logic [3:0] din = 4'd0;
  logic       err_clr = 1'b0;
  logic       dir = 1'b0;
  logic       locked, err_pulse, wrap_pulse;
  logic [3:0] expected;
  logic [7:0] err_count;

  int tests_run = 0;
  int failed    = 0;
  logic [3:0] e;   // bench's own model of the expected value
  int         n_err;

  always #5 clk = ~clk;

  count_sequence_checker dut (
    .clk        (clk),
    .re_n       (re_n),
    .din_valid  (din_valid),
    .din        (din),
`ifdef COUNT_CHK_DOWN_EN
    .dir        (dir),
`endif
    .err_clr    (err_clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .expected   (expected),
    .err_count  (err_count)
  );

  function automatic logic [3:0] nxt(input logic [3:0] x);
    return (x == 4'd7) ? 4'd0 : x + 4'd1;
  endfunction

  // Drive one cycle of stimulus, leave time for outputs to settle after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic clr);
    @(negedge clk);
    din_valid = v;
    din       = d;
    err_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    re_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({locked, err_pulse, wrap_pulse, expected, err_count} !== 15'd0)
      begin failed++; $display("FAIL reset_state: got %h want 0", {locked, err_pulse, wrap_pulse, expected, err_count}); end
    @(negedge clk);
    re_n = 1'b1;
  endtask

  task automatic test_lock();
    step(1, 4'd0, 0);
    tests_run++;
    if ({locked, expected} !== {1'b0, 4'd1})
      begin failed++; $display("FAIL lock_first: got %b/%0d want 0/1", locked, expected); end
    step(1, 4'd1, 0);
    tests_run++;
    if (locked !== 1'b0)
      begin failed++; $display("FAIL lock_early: got %b want 0", locked); end
    step(1, 4'd2, 0);
    tests_run++;
    if ({locked, expected, err_count} !== {1'b1, 4'd3, 8'd0})
      begin failed++; $display("FAIL lock_done: got %b/%0d/%0d want 1/3/0", locked, expected, err_count); end
  endtask

  task automatic test_wrap();
    for (int v = 3; v <= 6; v++) begin
      step(1, 4'(v), 0);
      tests_run++;
      if ({wrap_pulse, err_pulse, expected} !== {1'b0, 1'b0, 4'(v + 1)})
        begin failed++; $display("FAIL wrap_run%0d: got w%b e%b x%0d want 0/0/%0d", v, wrap_pulse, err_pulse, expected, v + 1); end
    end
    step(1, 4'd7, 0);
    tests_run++;
    if ({wrap_pulse, err_pulse, expected} !== {1'b1, 1'b0, 4'd0})
      begin failed++; $display("FAIL wrap_at7: got w%b e%b x%0d want 1/0/0", wrap_pulse, err_pulse, expected); end
    step(1, 4'd0, 0);
    tests_run++;
    if ({wrap_pulse, err_pulse, expected} !== {1'b0, 1'b0, 4'd1})
      begin failed++; $display("FAIL wrap_after: got w%b e%b x%0d want 0/0/1", wrap_pulse, err_pulse, expected); end
  endtask

  task automatic test_single_error();
    step(1, 4'd1, 0);
    step(1, 4'd2, 0);
    step(1, 4'd3, 0);
    step(1, 4'd9, 0);
    tests_run++;
    if ({err_pulse, err_count, locked, expected} !== {1'b1, 8'd1, 1'b1, 4'd5})
      begin failed++; $display("FAIL err_illegal: got p%b c%0d l%b x%0d want 1/1/1/5", err_pulse, err_count, locked, expected); end
    step(1, 4'd5, 0);
    tests_run++;
    if ({err_pulse, err_count, locked, expected} !== {1'b0, 8'd1, 1'b1, 4'd6})
      begin failed++; $display("FAIL err_recover: got p%b c%0d l%b x%0d want 0/1/1/6", err_pulse, err_count, locked, expected); end
    step(1, 4'd0, 0);
    step(1, 4'd7, 0);
    tests_run++;
    if ({wrap_pulse, err_count, locked} !== {1'b1, 8'd2, 1'b1})
      begin failed++; $display("FAIL err_flywheel: got w%b c%0d l%b want 1/2/1", wrap_pulse, err_count, locked); end
    step(1, 4'd3, 0);
    tests_run++;
    if ({err_pulse, err_count, locked, expected} !== {1'b1, 8'd3, 1'b1, 4'd1})
      begin failed++; $display("FAIL err_bad_cleared: got p%b c%0d l%b x%0d want 1/3/1/1", err_pulse, err_count, locked, expected); end
  endtask

  task automatic test_unlock();
    step(1, 4'd1, 0);
    step(1, 4'd2, 0);
    step(1, 4'd3, 0);
    step(1, 4'd2, 0);
    tests_run++;
    if ({err_pulse, err_count, locked, expected} !== {1'b1, 8'd4, 1'b1, 4'd5})
      begin failed++; $display("FAIL unlock_first: got p%b c%0d l%b x%0d want 1/4/1/5", err_pulse, err_count, locked, expected); end
    step(1, 4'd2, 0);
    tests_run++;
    if ({err_pulse, err_count, locked, expected} !== {1'b1, 8'd5, 1'b0, 4'd6})
      begin failed++; $display("FAIL unlock_second: got p%b c%0d l%b x%0d want 1/5/0/6", err_pulse, err_count, locked, expected); end
    step(1, 4'd2, 0);
    tests_run++;
    if ({err_pulse, err_count, locked, expected} !== {1'b0, 8'd5, 1'b0, 4'd3})
      begin failed++; $display("FAIL unlock_reseed: got p%b c%0d l%b x%0d want 0/5/0/3", err_pulse, err_count, locked, expected); end
  endtask

  task automatic test_illegal_hunt();
    step(1, 4'd12, 0);
    step(1, 4'd15, 0);
    tests_run++;
    if ({locked, err_pulse, expected, err_count} !== {1'b0, 1'b0, 4'd3, 8'd5})
      begin failed++; $display("FAIL hunt_illegal: got l%b p%b x%0d c%0d want 0/0/3/5", locked, err_pulse, expected, err_count); end
    step(1, 4'd6, 0);
    step(1, 4'd7, 0);
    tests_run++;
    if ({locked, wrap_pulse, expected} !== {1'b0, 1'b0, 4'd0})
      begin failed++; $display("FAIL sync_no_wrap: got l%b w%b x%0d want 0/0/0", locked, wrap_pulse, expected); end
    step(1, 4'd0, 0);
    tests_run++;
    if ({locked, expected} !== {1'b1, 4'd1})
      begin failed++; $display("FAIL relock: got l%b x%0d want 1/1", locked, expected); end
  endtask

  task automatic test_saturate_clear();
    e = 4'd1;
    n_err = 5;
    while (n_err < 255) begin
      step(1, 4'd9, 0); e = nxt(e); n_err++;
      step(1, e, 0);    e = nxt(e);
    end
    tests_run++;
    if ({err_count, locked} !== {8'd255, 1'b1})
      begin failed++; $display("FAIL sat_reach: got c%0d l%b want 255/1", err_count, locked); end
    step(1, 4'd9, 0); e = nxt(e);
    tests_run++;
    if ({err_pulse, err_count} !== {1'b1, 8'd255})
      begin failed++; $display("FAIL sat_hold: got p%b c%0d want 1/255", err_pulse, err_count); end
    step(1, e, 0); e = nxt(e);
    step(1, 4'd9, 1); e = nxt(e);
    tests_run++;
    if ({err_pulse, err_count, locked} !== {1'b1, 8'd0, 1'b1})
      begin failed++; $display("FAIL clr_wins: got p%b c%0d l%b want 1/0/1", err_pulse, err_count, locked); end
    step(1, e, 0); e = nxt(e);
    tests_run++;
    if ({err_pulse, err_count, locked, expected} !== {1'b0, 8'd0, 1'b1, e})
      begin failed++; $display("FAIL clr_after: got p%b c%0d l%b x%0d want 0/0/1/%0d", err_pulse, err_count, locked, expected, e); end
  endtask

  task automatic test_idle();
    int bad_idle = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 4'd9, 0);
      if ({locked, err_pulse, wrap_pulse, expected, err_count} !== {1'b1, 1'b0, 1'b0, e, 8'd0}) bad_idle++;
    end
    tests_run++;
    if (bad_idle != 0)
      begin failed++; $display("FAIL idle_hold: got %0d disturbed cycles want 0", bad_idle); end
    step(1, e, 0); e = nxt(e);
    tests_run++;
    if ({locked, err_pulse, expected, err_count} !== {1'b1, 1'b0, e, 8'd0})
      begin failed++; $display("FAIL idle_resume: got l%b p%b x%0d c%0d want 1/0/%0d/0", locked, err_pulse, expected, err_count, e); end
  endtask

  task automatic test_async_reset();
    step(1, 4'd9, 0);
    step(0, 4'd0, 0);
    @(negedge clk);
    #2;
    re_n = 1'b0;
    #1;
    tests_run++;
    if ({locked, err_pulse, wrap_pulse, expected, err_count} !== 15'd0)
      begin failed++; $display("FAIL async_reset: got %h want 0", {locked, err_pulse, wrap_pulse, expected, err_count}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    re_n = 1'b1;
    step(1, 4'd4, 0);
    step(1, 4'd5, 0);
    step(1, 4'd6, 0);
    tests_run++;
    if ({locked, expected, err_count} !== {1'b1, 4'd7, 8'd0})
      begin failed++; $display("FAIL reset_relock: got l%b x%0d c%0d want 1/7/0", locked, expected, err_count); end
    step(0, 4'd0, 0);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_single_error();
    test_unlock();
    test_illegal_hunt();
    test_saturate_clear();
    test_idle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
